// File: rtl/pulse_seq_pkg.sv
// Shared encodings and widths for the four-output pulse sequencer.
package pulse_seq_pkg;
   localparam int IDX_W = 2;
   localparam int TMR_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PHASE = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/pulse_seq_timer.sv
// Phase timer: clears on load, counts up when enabled, flags the last cycle of a phase.
module pulse_seq_timer
   import pulse_seq_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         count,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (count) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == last);

endmodule

// File: rtl/pulse_sequencer_4_outputs.sv
// Four-phase pulse sequencer with per-output inversion mask.
// Define PULSE_SEQ_LOOP_EN to repeat the sequence until Stop or reset.
module pulse_sequencer_4_outputs
   import pulse_seq_pkg::*;
#(
   parameter logic [3:0] BubblesMask = 4'b0001,
   parameter logic [7:0] PhaseLength = 8'd4
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic Start,
   input  logic Stop,
   output logic Output_1,
   output logic Output_2,
   output logic Output_3,
   output logic Output_4,
   output logic Busy,
   output logic Done
);

   // A zero length behaves as a one-cycle phase.
   localparam logic [TMR_W-1:0] LAST_COUNT =
      (PhaseLength == 8'd0) ? '0 : TMR_W'(PhaseLength - 8'd1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic               tc;
   logic               tmr_load;
   logic               tmr_en;
   logic [3:0]         act;
   logic [3:0]         out_vec;

   assign tmr_en   = (state_q == PHASE);
   assign tmr_load = (state_q != PHASE) || tc || Stop;

   pulse_seq_timer #(.W(TMR_W)) u_timer (
      .clk   (Clock),
      .rst_n (Reset_n),
      .load  (tmr_load),
      .count (tmr_en),
      .last  (LAST_COUNT),
      .tc    (tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = PHASE;
               idx_d   = '0;
            end
         end
         PHASE: begin
            if (tc) begin
               if (idx_q == '1) begin
                  idx_d  = '0;
                  done_d = 1'b1;
`ifdef PULSE_SEQ_LOOP_EN
                  state_d = PHASE;
`else
                  state_d = DONE;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
      // Stop overrides everything, including a pending Start or Done.
      if (Stop) begin
         state_d = IDLE;
         idx_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_act
      assign act[gi] = (state_q == PHASE) && (idx_q == IDX_W'(gi));
   end

   assign out_vec  = act ^ BubblesMask;
   assign Output_1 = out_vec[0];
   assign Output_2 = out_vec[1];
   assign Output_3 = out_vec[2];
   assign Output_4 = out_vec[3];
   assign Busy     = (state_q == PHASE);
   assign Done     = done_q;

endmodule

// File: tb/tb_pulse_sequencer_4_outputs.sv
// Bench for the pulse sequencer: table run, corner sequences, then random traffic vs a model.
module tb_pulse_sequencer_4_outputs;

   localparam logic [3:0] MASK  = 4'b0001;
   localparam int         LEN_A = 4;
   localparam int         LEN_B = 0;

   logic Clock;
   logic Reset_n;
   logic Start;
   logic Stop;
   logic o1_a, o2_a, o3_a, o4_a, busy_a, done_a;
   logic o1_b, o2_b, o3_b, o4_b, busy_b, done_b;
   logic [5:0] vec_a, vec_b;

   int checks = 0;
   int errors = 0;
   int pos_a  = -1;
   int pos_b  = -1;

   pulse_sequencer_4_outputs #(.BubblesMask(MASK), .PhaseLength(8'(LEN_A))) dut_a (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
      .Output_1(o1_a), .Output_2(o2_a), .Output_3(o3_a), .Output_4(o4_a),
      .Busy(busy_a), .Done(done_a)
   );

   pulse_sequencer_4_outputs #(.BubblesMask(MASK), .PhaseLength(8'(LEN_B))) dut_b (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
      .Output_1(o1_b), .Output_2(o2_b), .Output_3(o3_b), .Output_4(o4_b),
      .Busy(busy_b), .Done(done_b)
   );

   assign vec_a = {o4_a, o3_a, o2_a, o1_a, busy_a, done_a};
   assign vec_b = {o4_b, o3_b, o2_b, o1_b, busy_b, done_b};

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Model: pos counts cycles since the sequence began (-1 = idle).
   function automatic logic [5:0] expect_of(input int pos, input int len, input logic [3:0] mask);
      int         l;
      int         idx;
      logic       busy;
      logic       done;
      logic [3:0] act;
      l = (len == 0) ? 1 : len;
`ifdef PULSE_SEQ_LOOP_EN
      busy = (pos >= 0);
      done = (pos > 0) && ((pos % (4 * l)) == 0);
      idx  = (pos < 0) ? 0 : (pos % (4 * l)) / l;
`else
      busy = (pos >= 0) && (pos < 4 * l);
      done = (pos == 4 * l);
      idx  = busy ? pos / l : 0;
`endif
      act = busy ? (4'b0001 << idx) : 4'b0000;
      return {act ^ mask, busy, done};
   endfunction

   function automatic int next_pos(input int pos, input int len, input logic s, input logic p);
      int l;
      l = (len == 0) ? 1 : len;
      if (p) return -1;
      if (pos < 0) return s ? 0 : -1;
`ifndef PULSE_SEQ_LOOP_EN
      if (pos >= 4 * l) return -1;
`endif
      return pos + 1;
   endfunction

   task automatic chk(input string name, input logic [5:0] actual, input logic [5:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got {out4..1,busy,done}=%b expected %b at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic cycle(input logic s, input logic p);
      Start = s;
      Stop  = p;
      @(posedge Clock);
      pos_a = next_pos(pos_a, LEN_A, s, p);
      pos_b = next_pos(pos_b, LEN_B, s, p);
      #1;
      chk("model_a", vec_a, expect_of(pos_a, LEN_A, MASK));
      chk("model_b", vec_b, expect_of(pos_b, LEN_B, MASK));
   endtask

   task automatic do_reset();
      #1;
      Reset_n = 1'b0;
      #1;
      chk("reset_a", vec_a, {MASK, 2'b00});
      chk("reset_b", vec_b, {MASK, 2'b00});
      pos_a = -1;
      pos_b = -1;
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   typedef struct {
      logic       start;
      logic       stop;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[20];

   initial begin
      for (int i = 0; i < 4; i++)   tbl[i] = '{1'b0, 1'b0, 6'b0000_10};
      for (int i = 4; i < 8; i++)   tbl[i] = '{1'b0, 1'b0, 6'b0011_10};
      for (int i = 8; i < 12; i++)  tbl[i] = '{1'b0, 1'b0, 6'b0101_10};
      for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 6'b1001_10};
      tbl[0].start = 1'b1;
      tbl[16] = '{1'b0, 1'b0, 6'b0001_01};
      tbl[17] = '{1'b0, 1'b0, 6'b0001_00};
      tbl[18] = '{1'b1, 1'b1, 6'b0001_00};
      tbl[19] = '{1'b0, 1'b0, 6'b0001_00};

      Reset_n = 1'b0;
      Start   = 1'b0;
      Stop    = 1'b0;
      repeat (2) @(negedge Clock);
      chk("reset_state_a", vec_a, 6'b0001_00);
      chk("reset_state_b", vec_b, 6'b0001_00);
      Reset_n = 1'b1;

`ifndef PULSE_SEQ_LOOP_EN
      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].start, tbl[i].stop);
         chk($sformatf("table_%0d", i), vec_a, tbl[i].exp);
         if (i == 4) chk("len0_done_cycle5", vec_b, 6'b0001_01);
      end

      // Abort: Stop during cycle 6 of a sequence.
      cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      chk("abort_idle", vec_a, 6'b0001_00);
      repeat (20) cycle(1'b0, 1'b0);

      // Start during a sequence is not queued.
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      repeat (15) cycle(1'b0, 1'b0);
      chk("ignored_start_idle", vec_a, 6'b0001_00);

      // Start held high restarts right after the one-cycle Done.
      repeat (19) cycle(1'b1, 1'b0);
      chk("held_start_restart", vec_a, 6'b0000_10);
      repeat (3) cycle(1'b0, 1'b0);

      // Reset mid-sequence, then Start on the first edge after release.
      do_reset();
      cycle(1'b1, 1'b0);
      chk("start_after_reset", vec_a, 6'b0000_10);
      repeat (20) cycle(1'b0, 1'b0);
`else
      cycle(1'b1, 1'b0);
      for (int c = 2; c <= 40; c++) begin
         cycle(1'b0, 1'b0);
         if (c == 17 || c == 33) chk($sformatf("loop_done_%0d", c), vec_a, 6'b0000_11);
      end
      cycle(1'b0, 1'b1);
      chk("loop_stop_idle", vec_a, 6'b0001_00);
`endif

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
